// File: rtl/mimo_dsp_pkg.sv
// Shared types and saturation helpers for the multi-lane DSP pipeline.
package mimo_dsp_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_OFFSET = 2'd1,
        MODE_GAIN   = 2'd2,
        MODE_ACC    = 2'd3
    } mode_e;

    // Working width of the saturate helpers; callers sign-extend into it.
    localparam int unsigned SAT_W = 64;

    // Clamp v to the signed range of a w-bit result.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) begin
            saturate = hi;
        end else if (v < lo) begin
            saturate = lo;
        end else begin
            saturate = v;
        end
    endfunction

    // True when saturate() would clamp v.
    function automatic logic sat_overflow(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo = ~hi;
        sat_overflow = (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/mimo_dsp_lane.sv
// One lane: stage-1 arithmetic, per-lane accumulator, stage-2 saturation register.
module mimo_dsp_lane
    import mimo_dsp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned GAIN_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic                         accept_i,
    input  mode_e                        mode_i,
    input  logic signed [DATA_WIDTH-1:0] offset_i,
    input  logic        [GAIN_WIDTH-1:0] gain_i,
    input  logic                         clr_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    output logic signed [DATA_WIDTH-1:0] y_o,
    output logic                         sat_o
);

    // Wide enough for the full signed x * zero-extended gain product.
    localparam int unsigned WW = DATA_WIDTH + GAIN_WIDTH + 1;

    logic signed [WW-1:0]         x_w, off_w, gain_w, prod, acc_base, acc_sum;
    logic signed [WW-1:0]         s1_d, s1_q;
    logic signed [DATA_WIDTH-1:0] acc_d, acc_q;
    logic signed [DATA_WIDTH-1:0] y_d, y_q;
    logic                         sat_d, sat_q;

    always_comb begin
        x_w      = WW'(x_i);
        off_w    = WW'(offset_i);
        gain_w   = WW'({1'b0, gain_i});
        prod     = x_w * gain_w;
        acc_base = clr_i ? '0 : WW'(acc_q);
        acc_sum  = acc_base + x_w;

        unique case (mode_i)
            MODE_OFFSET: s1_d = x_w + off_w;
            MODE_GAIN:   s1_d = prod >>> FRAC_BITS;
            MODE_ACC:    s1_d = acc_sum;
            default:     s1_d = x_w;
        endcase

        // Accumulator only moves on accepted beats; clear wins over the old value.
        acc_d = acc_q;
        if (accept_i) begin
            if (mode_i == MODE_ACC) begin
                acc_d = DATA_WIDTH'(saturate(SAT_W'(acc_sum), DATA_WIDTH));
            end else if (clr_i) begin
                acc_d = '0;
            end
        end

        y_d   = DATA_WIDTH'(saturate(SAT_W'(s1_q), DATA_WIDTH));
        sat_d = sat_overflow(SAT_W'(s1_q), DATA_WIDTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= '0;
            acc_q <= '0;
            y_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                s1_q  <= s1_d;
                y_q   <= y_d;
                sat_q <= sat_d;
            end
        end
    end

    assign y_o   = y_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/mimo_dsp_pipe.sv
// N-lane two-stage DSP pipeline with valid/ready flow control and shared stall.
module mimo_dsp_pipe
    import mimo_dsp_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned GAIN_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              cfg_mode,
    input  logic [DATA_WIDTH-1:0]   cfg_offset,
    input  logic [GAIN_WIDTH-1:0]   cfg_gain,
    input  logic                    acc_clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*DATA_WIDTH-1:0] out_data,
    output logic [N-1:0]            sat_flags
);

    logic  stall_c, load_c, accept_c;
    logic  s1_valid_q, out_valid_q;
    mode_e mode_c;

    // Whole pipe freezes while the output beat is held by the sink.
    assign stall_c  = out_valid_q && !out_ready;
    assign load_c   = !stall_c;
    assign in_ready = load_c;
    assign accept_c = in_valid && load_c;
    assign mode_c   = mode_e'(cfg_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (load_c) begin
            s1_valid_q  <= accept_c;
            out_valid_q <= s1_valid_q;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar g = 0; g < N; g++) begin : g_lane
        mimo_dsp_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .GAIN_WIDTH (GAIN_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load_c),
            .accept_i (accept_c),
            .mode_i   (mode_c),
            .offset_i (cfg_offset),
            .gain_i   (cfg_gain),
            .clr_i    (acc_clear),
            .x_i      (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .y_o      (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .sat_o    (sat_flags[g])
        );
    end

endmodule
